dds_adc_integrator: RTL and testbench
=====================================

// Module: dds_adc_integrator
// PURPOSE
//  Integrate-and-dump stage directly downstream of the DDS x ADC signed multiplier (mixer).
//  Sums N mixer products per measurement, after discarding a programmable number of
//  settling samples, to give one lock-in I or Q value per frequency point.
//  Aligns the ADC sample strobe to the multiplier's fixed pipeline latency.
// PARAMETERS
//  IN_W     32  width of signed mixer product p_in
//  ACC_W    64  width of signed accumulator/result (IN_W < ACC_W <= 64)
//  CNT_W    24  width of sample and settle counters
//  MUL_LAT  3   cycles from sample at multiplier input to matching p_in (multiplier register depth)
// PORTS
//  clk           in   1      system clock, single domain
//  rst           in   1      synchronous active-high reset
//  sample_valid  in   1      ADC/DDS sample strobe, aligned with multiplier inputs
//  p_in          in   IN_W   signed mixer product (multiplier output p)
//  start         in   1      1-cycle pulse: begin a measurement
//  abort         in   1      1-cycle pulse: cancel measurement, no result
//  n_samples     in   CNT_W  products to accumulate; latched on accepted start
//  n_settle      in   CNT_W  products to discard first; latched on accepted start
//  busy          out  1      high from accepted start until result_valid or abort
//  result        out  ACC_W  signed accumulated sum; held until next result
//  result_valid  out  1      1-cycle pulse when result updates
//  overflow      out  1      sticky: saturation occurred in the current/last measurement
// BEHAVIOUR
//  Reset (sync, rst=1 at clk edge): state=IDLE; busy=0, result=0, result_valid=0,
//   overflow=0, accumulator=0, counters=0, valid delay line all 0. Overrides start/abort.
//  Alignment: pvalid = sample_valid delayed exactly MUL_LAT cycles (shift register).
//   p_in is sampled only on cycles where pvalid=1; it is ignored otherwise.
//  FSM states:
//   IDLE   : busy=0. start=1 -> latch n_samples/n_settle, acc=0, cnt=0, overflow=0, busy=1;
//            next = SETTLE if n_settle!=0, else ACCUM if n_samples!=0, else DONE.
//   SETTLE : each pvalid increments cnt; p_in discarded. On pvalid with cnt==n_settle-1:
//            cnt=0; next = ACCUM (or DONE if n_samples==0).
//   ACCUM  : each pvalid: acc = sat(acc + sext(p_in)), cnt++. On pvalid with
//            cnt==n_samples-1: next = DONE.
//   DONE   : result<=acc, result_valid=1 for this one cycle, busy=0; next = IDLE.
//  Latency: result_valid asserts 1 cycle after the edge that accepted the last product
//   (MUL_LAT+1 cycles after its sample_valid). n_samples=0: result=0, result_valid
//   1 cycle after start (plus settle time if n_settle!=0).
//  Arithmetic: p_in sign-extended to ACC_W; sum computed at ACC_W+1 bits; on signed
//   overflow clamp to 2^(ACC_W-1)-1 or -2^(ACC_W-1) and set overflow (sticky until next start).
//   Saturated acc keeps accumulating from the clamped value.
//  start while busy: ignored (latched values unchanged). start and abort in same cycle:
//   abort wins in SETTLE/ACCUM; in IDLE abort is a no-op and start is accepted.
//  abort in SETTLE/ACCUM: next=IDLE, busy=0 next cycle, no result_valid, result unchanged.
//   abort in DONE: ignored (result is still delivered).
//  Counters never wrap: max n_samples/n_settle = 2^CNT_W-1.
//  Delay line keeps running in all states; pvalid pulses during IDLE/DONE are dropped.
// TESTING
//  1 n_settle=0,n_samples=4, products 100,200,-50,7 on 4 pvalids -> result=257, one
//    result_valid pulse MUL_LAT+1 cycles after 4th sample_valid, busy low same cycle.
//  2 sample_valid with gaps (1,0,0,1,1,0,1), p_in=0xDEAD on non-valid cycles, n=4,
//    valid products 1,2,3,4 -> result=10 (garbage ignored).
//  3 n_settle=2,n_samples=2, products 1000,1000,5,6 -> result=11, overflow=0.
//  4 ACC_W=40, 600 products of 0x7FFFFFFF -> result=2^39-1, overflow=1; next start with
//    n=1,p=-3 -> overflow=0, result=-3.
//  5 n_samples=0,n_settle=0 -> result=0, result_valid 1 cycle after start; start pulse
//    during a busy run leaves result of that run unchanged.
//  6 abort (and separately rst) mid-ACCUM after 3 of 8 products -> busy=0, no
//    result_valid, result holds prior value (0 after rst); fresh run of n=2 (4,5) -> 9.

Source files
------------

// File: rtl/dds_adc_integrator.sv
// Integrate-and-dump stage behind the DDS x ADC mixer: discards settling products,
// then sums N saturating products into one lock-in I/Q value per frequency point.
module dds_adc_integrator #(
   parameter int IN_W    = 32,
   parameter int ACC_W   = 64,
   parameter int CNT_W   = 24,
   parameter int MUL_LAT = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             sample_valid,
   input  logic [IN_W-1:0]  p_in,
   input  logic             start,
   input  logic             abort,
   input  logic [CNT_W-1:0] n_samples,
   input  logic [CNT_W-1:0] n_settle,
   output logic             busy,
   output logic [ACC_W-1:0] result,
   output logic             result_valid,
   output logic             overflow
);

   // state  | meaning
   // IDLE   | waiting for start
   // SETTLE | discarding n_settle products
   // ACCUM  | summing n_samples products
   // DONE   | result delivered this cycle

   typedef enum logic [1:0] {IDLE, SETTLE, ACCUM, DONE} state_t;

   state_t             state;
   logic [MUL_LAT-1:0] vld_sr;
   logic               pvalid;
   logic [CNT_W-1:0]   n_samples_q;
   logic [CNT_W-1:0]   n_settle_q;
   logic [CNT_W-1:0]   cnt;
   logic [ACC_W-1:0]   acc;
   logic [ACC_W:0]     sum_ext;
   logic               sum_ovf;
   logic [ACC_W-1:0]   sum_sat;
   logic               settle_last;
   logic               accum_last;

   // Strobe delay matching the multiplier register depth; runs in every state.
   generate
      if (MUL_LAT == 1) begin : g_lat1
         always_ff @(posedge clk) begin
            if (rst) vld_sr <= '0;
            else     vld_sr <= sample_valid;
         end
      end else begin : g_latn
         always_ff @(posedge clk) begin
            if (rst) vld_sr <= '0;
            else     vld_sr <= {vld_sr[MUL_LAT-2:0], sample_valid};
         end
      end
   endgenerate

   assign pvalid = vld_sr[MUL_LAT-1];

   assign sum_ext = {acc[ACC_W-1], acc} + {{(ACC_W+1-IN_W){p_in[IN_W-1]}}, p_in};
   assign sum_ovf = sum_ext[ACC_W] ^ sum_ext[ACC_W-1];
   // The extra top bit carries the true sign, which picks the clamp direction.
   assign sum_sat = !sum_ovf        ? sum_ext[ACC_W-1:0] :
                    sum_ext[ACC_W]  ? {1'b1, {(ACC_W-1){1'b0}}} :
                                      {1'b0, {(ACC_W-1){1'b1}}};

   assign settle_last = (cnt == n_settle_q  - CNT_W'(1));
   assign accum_last  = (cnt == n_samples_q - CNT_W'(1));

   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= IDLE;
         busy         <= 1'b0;
         result       <= '0;
         result_valid <= 1'b0;
         overflow     <= 1'b0;
         acc          <= '0;
         cnt          <= '0;
         n_samples_q  <= '0;
         n_settle_q   <= '0;
      end else begin
         result_valid <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  n_samples_q <= n_samples;
                  n_settle_q  <= n_settle;
                  acc         <= '0;
                  cnt         <= '0;
                  overflow    <= 1'b0;
                  if (n_settle != '0) begin
                     state <= SETTLE;
                     busy  <= 1'b1;
                  end else if (n_samples != '0) begin
                     state <= ACCUM;
                     busy  <= 1'b1;
                  end else begin
                     state        <= DONE;
                     result       <= '0;
                     result_valid <= 1'b1;
                  end
               end
            end

            SETTLE: begin
               if (abort) begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end else if (pvalid) begin
                  if (settle_last) begin
                     cnt <= '0;
                     if (n_samples_q != '0) begin
                        state <= ACCUM;
                     end else begin
                        state        <= DONE;
                        result       <= acc;
                        result_valid <= 1'b1;
                        busy         <= 1'b0;
                     end
                  end else begin
                     cnt <= cnt + CNT_W'(1);
                  end
               end
            end

            ACCUM: begin
               if (abort) begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end else if (pvalid) begin
                  acc <= sum_sat;
                  if (sum_ovf) overflow <= 1'b1;
                  if (accum_last) begin
                     state        <= DONE;
                     result       <= sum_sat;
                     result_valid <= 1'b1;
                     busy         <= 1'b0;
                  end else begin
                     cnt <= cnt + CNT_W'(1);
                  end
               end
            end

            DONE: begin
               state <= IDLE;
            end

            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_dds_adc_integrator.sv
// Directed bench for dds_adc_integrator: a transaction-level model predicts each
// measurement's sum and delivery cycle; a per-cycle compare process checks the outputs.
module tb_dds_adc_integrator;
   localparam int IN_W    = 32;
   localparam int ACC_W   = 40;
   localparam int CNT_W   = 24;
   localparam int MUL_LAT = 3;
   localparam longint MAXV = (longint'(1) <<< (ACC_W-1)) - 1;
   localparam longint MINV = -(longint'(1) <<< (ACC_W-1));

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             sample_valid = 1'b0;
   logic [IN_W-1:0]  p_in = '0;
   logic             start = 1'b0;
   logic             abort = 1'b0;
   logic [CNT_W-1:0] n_samples = '0;
   logic [CNT_W-1:0] n_settle = '0;
   logic             busy;
   logic [ACC_W-1:0] result;
   logic             result_valid;
   logic             overflow;

   dds_adc_integrator #(.IN_W(IN_W), .ACC_W(ACC_W), .CNT_W(CNT_W), .MUL_LAT(MUL_LAT)) dut (
      .clk(clk), .rst(rst), .sample_valid(sample_valid), .p_in(p_in),
      .start(start), .abort(abort), .n_samples(n_samples), .n_settle(n_settle),
      .busy(busy), .result(result), .result_valid(result_valid), .overflow(overflow)
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_fail = 0;
   int cyc = 0;
   logic [IN_W-1:0] vq [int];

   // model expectations
   bit               chk_en = 1'b0;
   int               busy_lo = -1, busy_end = -1, rv_cyc = -1, clr_cyc = -1, last_cyc = 0;
   logic [ACC_W-1:0] exp_res = '0, pend_res = '0;
   bit               exp_ovf = 1'b0, pend_ovf = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   // Mixer product for a sample appears MUL_LAT cycles after its strobe; garbage otherwise.
   always @(posedge clk) begin
      #2;
      p_in = vq.exists(cyc - MUL_LAT) ? vq[cyc - MUL_LAT] : 32'h0000DEAD;
   end

   function automatic void chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s at cycle %0d: got %0h expected %0h", nm, cyc, got, exp);
      end
   endfunction

   always @(negedge clk) begin
      if (chk_en) begin
         bit eb;
         eb = (cyc >= busy_lo) && (cyc < busy_end);
         if (cyc == clr_cyc) begin
            exp_res = '0;
            exp_ovf = 1'b0;
         end
         if (cyc == rv_cyc) begin
            exp_res = pend_res;
            exp_ovf = pend_ovf;
         end
         chk("result_valid", 64'(result_valid), 64'(cyc == rv_cyc));
         chk("busy", 64'(busy), 64'(eb));
         chk("result", 64'(result), 64'(exp_res));
         if (!eb) chk("overflow", 64'(overflow), 64'(exp_ovf));
      end
   end

   function automatic void model(input longint vals[$], input int n_set,
                                 output logic [ACC_W-1:0] r, output bit o);
      longint a;
      a = 0;
      o = 1'b0;
      for (int i = n_set; i < vals.size(); i++) begin
         a = a + vals[i];
         if (a > MAXV) begin a = MAXV; o = 1'b1; end
         if (a < MINV) begin a = MINV; o = 1'b1; end
      end
      r = a[ACC_W-1:0];
   endfunction

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk); #1;
         start = 1'b0;
         abort = 1'b0;
         sample_valid = 1'b0;
      end
   endtask

   task automatic begin_run(input int n_set, input int n_smp);
      @(posedge clk); #1;
      start = 1'b1;
      n_settle = CNT_W'(n_set);
      n_samples = CNT_W'(n_smp);
      busy_lo = cyc + 1;
      if (n_set == 0 && n_smp == 0) begin
         rv_cyc = cyc + 1;
         busy_end = cyc + 1;
         pend_res = '0;
         pend_ovf = 1'b0;
      end else begin
         rv_cyc = -1;
         busy_end = 1 << 30;
      end
   endtask

   task automatic send(input longint vals[$], input bit pat[$], input int start_at);
      int i, k;
      i = 0;
      k = 0;
      while (i < vals.size()) begin
         @(posedge clk); #1;
         start = (k == start_at);
         if (k == start_at) n_samples = CNT_W'(1);
         if (pat[k % pat.size()]) begin
            sample_valid = 1'b1;
            vq[cyc] = vals[i][IN_W-1:0];
            last_cyc = cyc;
            i++;
         end else begin
            sample_valid = 1'b0;
         end
         k++;
      end
      @(posedge clk); #1;
      sample_valid = 1'b0;
      start = 1'b0;
   endtask

   task automatic expect_done(input longint vals[$], input int n_set);
      model(vals, n_set, pend_res, pend_ovf);
      rv_cyc = last_cyc + MUL_LAT + 1;
      busy_end = rv_cyc;
   endtask

   task automatic full_run(input int n_set, input longint vals[$], input bit pat[$], input int start_at);
      begin_run(n_set, vals.size() - n_set);
      send(vals, pat, start_at);
      expect_done(vals, n_set);
      idle(MUL_LAT + 3);
   endtask

   initial begin
      longint v[$];
      bit all1[$];
      bit gaps[$];
      all1 = '{1'b1};
      gaps = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};

      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      chk_en = 1'b1;
      @(negedge clk);
      chk("reset_result", 64'(result), 64'd0);
      chk("reset_busy", 64'(busy), 64'd0);
      chk("reset_overflow", 64'(overflow), 64'd0);

      // 1: basic sum
      v = '{100, 200, -50, 7};
      full_run(0, v, all1, -1);
      chk("lit_sum_257", 64'(result), 64'd257);

      // 2: strobe gaps, garbage products ignored
      v = '{1, 2, 3, 4};
      full_run(0, v, gaps, -1);
      chk("lit_gaps_10", 64'(result), 64'd10);

      // 3: settle discard
      v = '{1000, 1000, 5, 6};
      full_run(2, v, all1, -1);
      chk("lit_settle_11", 64'(result), 64'd11);
      chk("lit_settle_ovf", 64'(overflow), 64'd0);

      // 4: positive saturation, then overflow cleared by the next start
      v = {};
      for (int i = 0; i < 600; i++) v.push_back(longint'(32'h7FFFFFFF));
      full_run(0, v, all1, -1);
      chk("lit_sat_max", 64'(result), 64'(MAXV));
      chk("lit_sat_ovf", 64'(overflow), 64'd1);
      v = '{-3};
      full_run(0, v, all1, -1);
      chk("lit_neg3", 64'(result), 64'(40'hFF_FFFF_FFFD));
      chk("lit_neg3_ovf", 64'(overflow), 64'd0);

      // 5: empty measurement, then a start pulse ignored mid-run
      begin_run(0, 0);
      idle(3);
      chk("lit_empty_0", 64'(result), 64'd0);
      v = '{1, 2, 3, 4};
      full_run(0, v, all1, 2);
      chk("lit_busy_start_10", 64'(result), 64'd10);

      // 6a: abort after 3 of 8 products
      begin_run(0, 8);
      v = '{11, 22, 33};
      send(v, all1, -1);
      @(posedge clk); #1;
      abort = 1'b1;
      busy_end = cyc + 1;
      @(posedge clk); #1;
      abort = 1'b0;
      idle(MUL_LAT + 3);
      chk("lit_abort_hold", 64'(result), 64'd10);
      v = '{4, 5};
      full_run(0, v, all1, -1);
      chk("lit_after_abort_9", 64'(result), 64'd9);

      // 6b: reset after 3 of 8 products
      begin_run(0, 8);
      v = '{11, 22, 33};
      send(v, all1, -1);
      @(posedge clk); #1;
      rst = 1'b1;
      busy_end = cyc + 1;
      clr_cyc = cyc + 1;
      @(posedge clk); #1;
      rst = 1'b0;
      idle(MUL_LAT + 3);
      chk("lit_rst_clear", 64'(result), 64'd0);
      v = '{4, 5};
      full_run(0, v, all1, -1);
      chk("lit_after_rst_9", 64'(result), 64'd9);

      idle(2);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

endmodule
